// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit for the EX stage, holding its result in HI/LO.
// One radix-2 shift-add or restoring-divide step per CALC cycle; sign fixup in FIX.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic        div_r, sa, sb;
    logic [31:0] ma, mb, a_raw;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        sgn_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] msum, trial;
    logic [63:0] acc_step, prod;
    logic [31:0] quo, rem, res_hi, res_lo;

    assign busy   = (state != IDLE);
    assign sgn_op = ~op[0];
    assign mag_a  = (sgn_op && A[31]) ? -A : A;
    assign mag_b  = (sgn_op && B[31]) ? -B : B;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !flush) state_next = CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        msum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? ma : 32'd0)};
        trial = {acc[63:32], acc[31]} - {1'b0, mb};
        if (div_r)
            acc_step = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
        else
            acc_step = {msum, acc[31:1]};
    end

    always_comb begin
        prod = (sa ^ sb) ? -acc : acc;
        quo  = acc[31:0];
        rem  = acc[63:32];
        if (div_r) begin
            // Divide by zero reports the raw dividend in HI and skips sign fixup.
            if (mb == 32'd0) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = sa ? -rem : rem;
                res_lo = (sa ^ sb) ? -quo : quo;
            end
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            div_r <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            a_raw <= '0;
            cnt   <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!flush) begin
                            div_r <= op[1];
                            sa    <= sgn_op & A[31];
                            sb    <= sgn_op & B[31];
                            ma    <= mag_a;
                            mb    <= mag_b;
                            a_raw <= A;
                            cnt   <= '0;
                            acc   <= {32'd0, (op[1] ? mag_a : mag_b)};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= acc_step;
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, timing,
// flush, reset, and start/write priority.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive a start for one cycle (optionally with a coincident HI write) and
    // wait for done; returns cycles from start edge, busy cycles, and the
    // busy/done values seen in the cycle after the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic we, output int cyc, output int bcnt,
                         output logic busy0, output logic done0);
        start = 1'b1; op = o; A = a; B = b;
        hi_we = we; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        A = ~a; B = ~b;
        busy0 = busy; done0 = done;
        bcnt = busy ? 1 : 0;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0", hi, lo, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int cyc, bcnt; logic b0, d0;
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL multu_latency: got %0d, want 33", cyc); end
        checks++;
        if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d, want 33", bcnt); end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max: hi=%h lo=%h, want fffffffe/00000001", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b, want 0", done); end
    endtask

    task automatic test_mult_signed();
        int cyc, bcnt; logic b0, d0;
        do_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_neg: hi=%h lo=%h, want ffffffff/ffffffeb", hi, lo);
        end
        @(negedge clk);
        do_op(MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            errors++; $display("FAIL mult_minmin: hi=%h lo=%h, want 40000000/00000000", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_divide();
        int cyc, bcnt; logic b0, d0;
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_neg: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
        end
        @(negedge clk);
        do_op(DIVU, 32'd100, 32'd7, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL divu_100_7: hi=%h lo=%h, want 00000002/0000000e", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_div_boundary();
        int cyc, bcnt; logic b0, d0;
        do_op(DIVU, 32'd100, 32'd0, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu_by_zero: hi=%h lo=%h, want 00000064/ffffffff", hi, lo);
        end
        @(negedge clk);
        do_op(DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_by_zero_neg: hi=%h lo=%h, want fffffff9/ffffffff", hi, lo);
        end
        @(negedge clk);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div_overflow: hi=%h lo=%h, want 00000000/80000000", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen;
        hi_we = 1'b1; wdata = 32'h1111_1111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
        @(negedge clk);
        lo_we = 1'b0;
        checks++;
        if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h, want 11111111/22222222", hi, lo);
        end
        start = 1'b1; op = MULTU; A = 32'd3; B = 32'd5;
        @(negedge clk);                       // after edge 0
        start = 1'b0;
        repeat (9) @(negedge clk);            // after edge 9
        flush = 1'b1;
        @(negedge clk);                       // after edge 10
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle: busy=%b done=%b, want 0/0", busy, done);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            errors++; $display("FAIL flush_result: done_cnt=%0d hi=%h lo=%h, want 0/11111111/22222222", seen, hi, lo);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        start = 1'b1; op = DIVU; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MULTU; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cyc = 5;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL start_while_busy: cyc=%0d hi=%h lo=%h, want 33/00000002/0000000e", cyc, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        start = 1'b1; op = MULTU; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_calc: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0", hi, lo, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_priority();
        int cyc, bcnt; logic b0, d0;
        do_op(MULTU, 32'd2, 32'd3, 1'b1, cyc, bcnt, b0, d0);
        checks++;
        if (b0 !== 1'b1) begin errors++; $display("FAIL start_over_we_busy: busy=%b, want 1", b0); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++; $display("FAIL start_over_we: hi=%h lo=%h, want 00000000/00000006", hi, lo);
        end
        // hi_we while busy must be ignored
        start = 1'b1; op = DIVU; A = 32'd50; B = 32'd8;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        cyc = 3;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd6) begin
            errors++; $display("FAIL we_while_busy: hi=%h lo=%h, want 00000002/00000006", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt; logic b0, d0;
        do_op(DIVU, 32'd100, 32'd7, 1'b0, cyc, bcnt, b0, d0);
        // second start issued in the done cycle
        do_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc, bcnt, b0, d0);
        checks++;
        if (b0 !== 1'b1 || d0 !== 1'b0) begin
            errors++; $display("FAIL b2b_handoff: busy=%b done=%b, want 1/0", b0, d0);
        end
        checks++;
        if (cyc !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL b2b_result: cyc=%0d hi=%h lo=%h, want 33/ffffffff/ffffffeb", cyc, hi, lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_boundary();
        test_flush();
        test_start_while_busy();
        test_reset_mid_calc();
        test_write_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
